// File: rtl/ad9467_axis_packetizer_if.sv
// Stream pair of the AD9467 packetizer: 16-bit samples in, packed 32-bit words out.
// "master" is the packetizer's side; "slave" is the side of the capture FIFO and downstream sink.
interface ad9467_axis_packetizer_if;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport master (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/ad9467_axis_packetizer.sv
// Packs ADC sample pairs into tlast-framed 32-bit words; a word is valid one cycle after its 2nd sample,
// s_axis_tready follows the single output stage. Define AD9467_PKT_HEADER_EN to prefix each packet with a header.
module ad9467_axis_packetizer #(
    parameter int PACKET_WORDS = 256,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                     m_aclk,
    input  logic                     m_areset,
    input  logic                     enable,
    input  logic                     clear_status,
    input  logic                     fifo_overflow,
    ad9467_axis_packetizer_if.master axis,
    output logic [COUNT_WIDTH-1:0]   pkt_count,
    output logic [COUNT_WIDTH-1:0]   ovf_count,
    output logic                     ovf_sticky,
    output logic                     busy
);
    localparam int WCNT_W = $clog2(PACKET_WORDS);
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(PACKET_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef AD9467_PKT_HEADER_EN
        ST_HDR,
`endif
        ST_DATA
    } state_t;

`ifdef AD9467_PKT_HEADER_EN
    localparam state_t ST_START = ST_HDR;
`else
    localparam state_t ST_START = ST_DATA;
`endif

    state_t                 r_state;
    logic                   r_phase;
    logic [15:0]            r_low;
    logic [WCNT_W-1:0]      r_word_cnt;
    logic [31:0]            r_tdata;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [COUNT_WIDTH-1:0] r_pkt_count;
    logic [COUNT_WIDTH-1:0] r_ovf_count;
    logic                   r_ovf_sticky;
    logic                   r_ovf_d;

    logic w_out_load;
    logic w_in_rdy;
    logic w_accept;
    logic w_word_last;
    logic w_ovf_edge;

    // The output stage may take a new word whenever it is empty or being drained this cycle.
    assign w_out_load  = !r_tvalid || axis.m_axis_tready;
    assign w_in_rdy    = (r_state == ST_DATA) && w_out_load;
    assign w_accept    = w_in_rdy && axis.s_axis_tvalid;
    assign w_word_last = (r_word_cnt == LAST_IDX);
    assign w_ovf_edge  = fifo_overflow && !r_ovf_d;

    always_ff @(posedge m_aclk or posedge m_areset) begin
        if (m_areset) begin
            r_state     <= ST_IDLE;
            r_phase     <= 1'b0;
            r_low       <= '0;
            r_word_cnt  <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            if (r_tvalid && axis.m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_START;
                    end
                end
`ifdef AD9467_PKT_HEADER_EN
                ST_HDR: begin
                    // Sequence number is the count before this packet completes.
                    if (w_out_load) begin
                        r_tdata  <= {16'hA5A5, 16'(r_pkt_count)};
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    if (w_accept) begin
                        if (!r_phase) begin
                            r_low   <= axis.s_axis_tdata;
                            r_phase <= 1'b1;
                        end else begin
                            r_tdata  <= {axis.s_axis_tdata, r_low};
                            r_tvalid <= 1'b1;
                            r_tlast  <= w_word_last;
                            r_phase  <= 1'b0;
                            if (w_word_last) begin
                                r_word_cnt  <= '0;
                                r_pkt_count <= r_pkt_count + COUNT_WIDTH'(1);
                                r_state     <= enable ? ST_START : ST_IDLE;
                            end else begin
                                r_word_cnt <= r_word_cnt + WCNT_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A clear coinciding with a new edge keeps that edge rather than losing it.
    always_ff @(posedge m_aclk or posedge m_areset) begin
        if (m_areset) begin
            r_ovf_d      <= 1'b0;
            r_ovf_count  <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            r_ovf_d <= fifo_overflow;
            if (clear_status) begin
                r_ovf_count  <= w_ovf_edge ? COUNT_WIDTH'(1) : '0;
                r_ovf_sticky <= w_ovf_edge;
            end else if (w_ovf_edge) begin
                r_ovf_sticky <= 1'b1;
                if (r_ovf_count != '1) begin
                    r_ovf_count <= r_ovf_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign axis.s_axis_tready = w_in_rdy;
    assign axis.m_axis_tdata  = r_tdata;
    assign axis.m_axis_tvalid = r_tvalid;
    assign axis.m_axis_tlast  = r_tlast;
    assign pkt_count          = r_pkt_count;
    assign ovf_count          = r_ovf_count;
    assign ovf_sticky         = r_ovf_sticky;
    assign busy               = (r_state != ST_IDLE);
endmodule

// File: tb/tb_ad9467_axis_packetizer.sv
// Bench for ad9467_axis_packetizer: directed tables, corner sequences and randomized traffic
// compared against a packet-level model built from the accepted sample stream.
`timescale 1ns/1ps
module tb_ad9467_axis_packetizer;
    localparam int PW = 4;
    localparam int CW = 2;
`ifdef AD9467_PKT_HEADER_EN
    localparam int HOFS = 1;
`else
    localparam int HOFS = 0;
`endif

    logic          m_aclk        = 1'b0;
    logic          m_areset      = 1'b1;
    logic          enable        = 1'b0;
    logic          clear_status  = 1'b0;
    logic          fifo_overflow = 1'b0;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] ovf_count;
    logic          ovf_sticky;
    logic          busy;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          model_pkts = 0;
    int          last_span  = 0;
    bit          stop_src   = 1'b0;
    logic [15:0] src_q[$];
    logic [15:0] in_q[$];
    logic [32:0] out_q[$];

    ad9467_axis_packetizer_if u_if ();

    ad9467_axis_packetizer #(.PACKET_WORDS(PW), .COUNT_WIDTH(CW)) u_dut (
        .m_aclk        (m_aclk),
        .m_areset      (m_areset),
        .enable        (enable),
        .clear_status  (clear_status),
        .fifo_overflow (fifo_overflow),
        .axis          (u_if.master),
        .pkt_count     (pkt_count),
        .ovf_count     (ovf_count),
        .ovf_sticky    (ovf_sticky),
        .busy          (busy)
    );

    always #5 m_aclk = ~m_aclk;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void fail_to(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endfunction

    // Handshake monitor and output-hold checker.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat   = '0;
    logic        prev_last  = 1'b0;
    always @(negedge m_aclk) begin
        if (m_areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", u_if.m_axis_tvalid, 1);
                check("hold_dat", u_if.m_axis_tdata, prev_dat);
                check("hold_last", u_if.m_axis_tlast, prev_last);
            end
            if (u_if.m_axis_tvalid && !u_if.m_axis_tready)
                check("stall_s_rdy", u_if.s_axis_tready, 0);
            if (u_if.s_axis_tvalid && u_if.s_axis_tready)
                in_q.push_back(u_if.s_axis_tdata);
            if (u_if.m_axis_tvalid && u_if.m_axis_tready)
                out_q.push_back({u_if.m_axis_tlast, u_if.m_axis_tdata});
            prev_stall = u_if.m_axis_tvalid && !u_if.m_axis_tready;
            prev_dat   = u_if.m_axis_tdata;
            prev_last  = u_if.m_axis_tlast;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge m_aclk);
        #1;
    endtask

    // Presents src_q in order; must be entered at posedge+1.
    task automatic send(input bit rnd_valid, input bit rnd_ready);
        int  it    = 0;
        int  first = -1;
        int  last  = -1;
        bit  hs;
        while (src_q.size() > 0 && !stop_src && it < 3000) begin
            if (!u_if.s_axis_tvalid && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
                u_if.s_axis_tvalid = 1'b1;
                u_if.s_axis_tdata  = src_q[0];
            end
            if (rnd_ready) u_if.m_axis_tready = ($urandom_range(0, 3) != 0);
            @(negedge m_aclk);
            hs = u_if.s_axis_tvalid && u_if.s_axis_tready;
            @(posedge m_aclk);
            #1;
            if (hs) begin
                void'(src_q.pop_front());
                u_if.s_axis_tvalid = 1'b0;
                if (first < 0) first = it;
                last = it;
            end
            it++;
        end
        u_if.s_axis_tvalid = 1'b0;
        if (src_q.size() > 0 && !stop_src) begin
            fail_to("send_stall");
            src_q.delete();
        end
        last_span = last - first + 1;
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        while (busy && g < 1000) begin
            cyc(1);
            g++;
        end
        if (busy) fail_to({nm, "_idle"});
    endtask

    task automatic wait_out(input int n, input string nm);
        int g = 0;
        while (out_q.size() < n && g < 500) begin
            cyc(1);
            g++;
        end
        if (out_q.size() < n) fail_to({nm, "_wait_out"});
    endtask

    // Reference: whole packets of PW words built from consecutive accepted sample pairs.
    task automatic check_stream(input string nm);
        logic [32:0] exp_q[$];
        int npk;
        check({nm, "_whole_pkts"}, in_q.size() % (2 * PW), 0);
        npk = in_q.size() / (2 * PW);
        for (int p = 0; p < npk; p++) begin
            if (HOFS != 0) exp_q.push_back({1'b0, 16'hA5A5, 16'(model_pkts % (1 << CW))});
            for (int w = 0; w < PW; w++) begin
                int k;
                k = (p * PW + w) * 2;
                exp_q.push_back({(w == PW - 1), in_q[k + 1], in_q[k]});
            end
            model_pkts++;
        end
        check({nm, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check({nm, "_word"}, out_q[i], exp_q[i]);
        check({nm, "_pkt_count"}, pkt_count, model_pkts % (1 << CW));
        in_q.delete();
        out_q.delete();
    endtask

    typedef struct {
        logic [15:0] s0;
        logic [15:0] s1;
        logic [31:0] dat;
        logic        last;
    } vec_t;

    task automatic test_packing();
        vec_t vecs[4];
        vecs[0] = '{16'h0001, 16'h0002, 32'h00020001, 1'b0};
        vecs[1] = '{16'h0003, 16'h0004, 32'h00040003, 1'b0};
        vecs[2] = '{16'h0005, 16'h0006, 32'h00060005, 1'b0};
        vecs[3] = '{16'h0007, 16'h0008, 32'h00080007, 1'b1};
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(vecs[i].s0);
            src_q.push_back(vecs[i].s1);
        end
        u_if.m_axis_tready = 1'b1;
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        send(1'b0, 1'b0);
        check("pack_span", last_span, 8);
        wait_idle("pack");
        cyc(2);
        check("pack_len", out_q.size(), 4 + HOFS);
        for (int i = 0; i < 4; i++) begin
            if (i + HOFS < out_q.size()) begin
                check("pack_dat", out_q[i + HOFS][31:0], vecs[i].dat);
                check("pack_last", out_q[i + HOFS][32], vecs[i].last);
            end
        end
`ifdef AD9467_PKT_HEADER_EN
        if (out_q.size() > 0) check("hdr_first", out_q[0], {1'b0, 32'hA5A50000});
`endif
        check_stream("pack");
        check("pack_busy", busy, 0);
        check("pack_s_rdy", u_if.s_axis_tready, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) src_q.push_back(16'(16'h1000 + i));
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        fork
            send(1'b0, 1'b0);
            begin
                wait_out(1 + HOFS, "bp");
                u_if.m_axis_tready = 1'b0;
                cyc(5);
                u_if.m_axis_tready = 1'b1;
            end
        join
        wait_idle("bp");
        cyc(2);
        check_stream("bp");
    endtask

    task automatic test_disable();
        for (int i = 0; i < 8; i++) src_q.push_back(16'(16'h2000 + 3 * i));
        enable = 1'b1;
        fork
            send(1'b0, 1'b0);
            begin
                wait_out(2 + HOFS, "dis");
                enable = 1'b0;
            end
        join
        wait_idle("dis");
        cyc(2);
        check("dis_busy", busy, 0);
        check("dis_s_rdy", u_if.s_axis_tready, 0);
        if (out_q.size() == 4 + HOFS) check("dis_last4", out_q[3 + HOFS][32], 1);
        check_stream("dis");
    endtask

    task automatic ovf_pulse();
        fifo_overflow = 1'b1;
        cyc(1);
        fifo_overflow = 1'b0;
        cyc(1);
    endtask

    task automatic test_overflow();
        repeat (3) ovf_pulse();
        check("ovf_cnt3", ovf_count, 3);
        check("ovf_sticky3", ovf_sticky, 1);
        fifo_overflow = 1'b1;
        clear_status  = 1'b1;
        cyc(1);
        fifo_overflow = 1'b0;
        clear_status  = 1'b0;
        check("ovf_clr_edge_cnt", ovf_count, 1);
        check("ovf_clr_edge_sticky", ovf_sticky, 1);
        cyc(1);
        clear_status = 1'b1;
        cyc(1);
        clear_status = 1'b0;
        check("ovf_clr_cnt", ovf_count, 0);
        check("ovf_clr_sticky", ovf_sticky, 0);
        fifo_overflow = 1'b1;
        cyc(4);
        fifo_overflow = 1'b0;
        cyc(1);
        check("ovf_level_once", ovf_count, 1);
        repeat (4) ovf_pulse();
        check("ovf_saturate", ovf_count, 3);
        check("ovf_no_datapath", pkt_count, model_pkts % (1 << CW));
    endtask

    task automatic mid_reset(input string nm, input int ns, input bit rdy_after, input logic exp_vld);
        u_if.m_axis_tready = 1'b1;
        enable = 1'b1;
        cyc(1);
        for (int i = 0; i < ns; i++) src_q.push_back(16'(16'hE000 + i));
        send(1'b0, 1'b0);
        u_if.m_axis_tready = rdy_after;
        check({nm, "_pre_vld"}, u_if.m_axis_tvalid, exp_vld);
        check({nm, "_pre_busy"}, busy, 1);
        #1 m_areset = 1'b1;
        #1;
        check({nm, "_vld"}, u_if.m_axis_tvalid, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_s_rdy"}, u_if.s_axis_tready, 0);
        check({nm, "_pkt_count"}, pkt_count, 0);
        enable = 1'b0;
        cyc(2);
        m_areset = 1'b0;
        u_if.m_axis_tready = 1'b1;
        cyc(1);
        in_q.delete();
        out_q.delete();
        model_pkts = 0;
    endtask

    task automatic test_fresh_after_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(16'(16'h0100 + i));
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        send(1'b0, 1'b0);
        wait_idle("fresh");
        cyc(2);
        check("fresh_first", (out_q.size() > HOFS) ? out_q[HOFS] : 33'h0, {1'b0, 32'h01010100});
        check_stream("fresh");
    endtask

    task automatic rand_round(input string nm);
        int dly;
        src_q.delete();
        for (int i = 0; i < 600; i++) src_q.push_back(16'($urandom));
        stop_src = 1'b0;
        enable   = 1'b1;
        dly      = $urandom_range(20, 200);
        fork
            send(1'b1, 1'b1);
            begin
                cyc(dly);
                enable = 1'b0;
                wait_idle(nm);
                stop_src = 1'b1;
            end
        join
        stop_src = 1'b0;
        src_q.delete();
        u_if.m_axis_tready = 1'b1;
        cyc(3);
        check(nm, busy, 0);
        check_stream(nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        u_if.s_axis_tdata  = '0;
        u_if.s_axis_tvalid = 1'b0;
        u_if.m_axis_tready = 1'b1;
        cyc(3);
        check("rst_m_vld", u_if.m_axis_tvalid, 0);
        check("rst_m_dat", u_if.m_axis_tdata, 0);
        check("rst_m_last", u_if.m_axis_tlast, 0);
        check("rst_s_rdy", u_if.s_axis_tready, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_ovf_count", ovf_count, 0);
        check("rst_ovf_sticky", ovf_sticky, 0);
        check("rst_busy", busy, 0);
        m_areset = 1'b0;
        cyc(2);
        check("idle_s_rdy", u_if.s_axis_tready, 0);

        test_packing();
        test_backpressure();
        test_disable();
        test_overflow();
        mid_reset("rst_hold", 2, 1'b0, 1'b1);
        mid_reset("rst_part", 3, 1'b1, 1'b0);
        test_fresh_after_reset();
        rand_round("rnd0");
        rand_round("rnd1");
        rand_round("rnd2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
